bitonic_sort_ctrl: RTL and testbench
====================================

# bitonic_sort_ctrl

Step sequencer for the folded bitonic sorter. The design has one compare-swap stage array built from `compSwap` pairs, and that array is reused for every step of a full bitonic sort. This block accepts a DEPTH-element job through a ready/valid handshake. It then issues each step's sequence length and compare distance to the stage array, one step at a time, and presents a done handshake when the last merge step has been acknowledged. It holds no data: it only drives load, step and output strobes.

## Interface
- DEPTH, 8, number of elements per sort; power of two, at least 2. Localparams: L = $clog2(DEPTH), LW = $clog2(L+1), SW = $clog2(L*(L+1)/2 + 1).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- in_valid  input  1  a new unsorted vector is present on the datapath input.
- in_ready  output  1  controller can accept a job.
- descend  input  1  final sort order, sampled when a job is accepted (0 = ascending).
- load_en  output  1  capture the input vector into the working register.
- step_valid  output  1  a step command is presented.
- step_ack  input  1  the datapath has completed the presented step.
- seq_log  output  LW  log2 of the bitonic sequence length for this step (1..L).
- cd_log  output  LW  log2 of the compare distance (0..seq_log-1).
- dir_final  output  1  latched descend, used by the datapath to set per-pair direction.
- step_idx  output  SW  index of the current step, starting at 0.
- last_step  output  1  the current step is the final one.
- out_valid  output  1  the sorted vector is available.
- out_ready  input  1  downstream accepts the result.
- abort  input  1  synchronous job cancel.
- busy  output  1  state is not IDLE.

## Operation
- States are IDLE, RUN and DONE. Reset value is IDLE.
- **IDLE**
  - in_ready = 1.
  - load_en = in_valid & in_ready, combinational.
  - On acceptance: latch descend into dir_final, set seq_log=1, cd_log=0, step_idx=0, and go to RUN.
- **RUN**
  - step_valid = 1. seq_log, cd_log and step_idx stay stable until step_ack.
  - Advance on step_ack:
    - If cd_log > 0: decrement cd_log.
    - Else if seq_log < L: increment seq_log and set cd_log = new seq_log - 1.
    - Else: go to DONE.
  - step_idx increments on every ack.
  - last_step = (seq_log == L) & (cd_log == 0).
- **DONE**
  - out_valid = 1 until out_ready, then go to IDLE.
- Step order for DEPTH=8, as (seq_log, cd_log): (1,0) (2,1) (2,0) (3,2) (3,1) (3,0). That is 6 steps, L(L+1)/2 in general.
- DEPTH=2: a single step (1,0), with last_step high on it.
- step_ack outside RUN is ignored.
- Abort has highest priority in every state. It goes to IDLE on the next edge with no out_valid. Abort together with in_valid in IDLE produces no load_en and no state change.

## Timing
- Reset values:
  - in_ready = 1.
  - busy, load_en, step_valid, out_valid, last_step = 0.
  - seq_log, cd_log, step_idx = 0; dir_final = 0.
- in_ready, load_en, step_valid, out_valid, last_step and busy decode directly from registered state. Only load_en also depends combinationally on in_valid.
- Job accepted at edge n: step_valid = 1 from cycle n+1.
- With step_ack tied high, commands change every cycle. step_valid stays high continuously across steps with no bubble.
- The last ack at edge m gives out_valid = 1 from m+1. The handshake at edge d gives in_ready = 1 from d+1. There is no same-cycle DONE-to-accept bypass.
- Minimum job period is 1 + L(L+1)/2 + 1 cycles (8 for DEPTH=8).
- Asserting rst mid-job clears everything immediately, asynchronously. Release is synchronous to clk.

## Test plan
- **Reset:** hold rst=0 with random inputs. Require in_ready=1, all other outputs 0, and busy=0 for one cycle after release.
- **Full job, DEPTH=8:** step_ack=1 always and descend=1.
  - Require load_en for one cycle.
  - Require the (seq_log, cd_log) sequence (1,0),(2,1),(2,0),(3,2),(3,1),(3,0) with step_idx 0..5 and last_step only at idx 5.
  - Require dir_final=1 and out_valid 7 cycles after acceptance.
- **Stalled acks:** ack only every 3rd cycle. Commands stay stable while unacked. The sequence is the same as the full-job case, and step_idx never skips.
- **Output backpressure:** hold out_ready=0 for 5 cycles in DONE. out_valid stays 1 and in_ready stays 0; IDLE follows the cycle after out_ready=1.
- **Abort:**
  - Abort at step_idx=3: IDLE next cycle, no out_valid, and the next job restarts at (1,0).
  - Abort together with in_valid in IDLE: no load_en.
- **DEPTH=2 instance:** single step (1,0) with last_step=1, and out_valid on the following cycle.

Source files
------------

// File: rtl/bitonic_sort_ctrl_if.sv
// Handshake and step-command bundle between the bitonic step sequencer and the
// folded compare-swap datapath.
interface bitonic_sort_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int L  = $clog2(DEPTH);
    localparam int LW = $clog2(L + 1);
    localparam int SW = $clog2(L * (L + 1) / 2 + 1);

    logic          in_valid;
    logic          in_ready;
    logic          descend;
    logic          load_en;
    logic          step_valid;
    logic          step_ack;
    logic [LW-1:0] seq_log;
    logic [LW-1:0] cd_log;
    logic          dir_final;
    logic [SW-1:0] step_idx;
    logic          last_step;
    logic          out_valid;
    logic          out_ready;
    logic          abort;
    logic          busy;

    // master is the sequencer, slave is the datapath / job source
    modport master (
        input  in_valid, descend, step_ack, out_ready, abort,
        output in_ready, load_en, step_valid, seq_log, cd_log, dir_final,
               step_idx, last_step, out_valid, busy
    );

    modport slave (
        output in_valid, descend, step_ack, out_ready, abort,
        input  in_ready, load_en, step_valid, seq_log, cd_log, dir_final,
               step_idx, last_step, out_valid, busy
    );
endinterface

// File: rtl/bitonic_sort_ctrl.sv
// Step sequencer for the folded bitonic sorter: walks (seq_log, cd_log) through
// every merge step of a DEPTH-element sort, one acknowledged step at a time.
module bitonic_sort_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    bitonic_sort_ctrl_if.master bus
);
    localparam int L  = $clog2(DEPTH);
    localparam int LW = $clog2(L + 1);
    localparam int SW = $clog2(L * (L + 1) / 2 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] seq_log;
    logic [LW-1:0] cd_log;
    logic [SW-1:0] step_idx;
    logic          dir_final;

    // NOTE: state uses non-blocking assignments only, so every branch below reads
    // the pre-edge values and the command fields update together on the ack edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            seq_log   <= '0;
            cd_log    <= '0;
            step_idx  <= '0;
            dir_final <= 1'b0;
        end else if (bus.abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dir_final <= bus.descend;
                        seq_log   <= LW'(1);
                        cd_log    <= '0;
                        step_idx  <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.step_ack) begin
                        step_idx <= step_idx + SW'(1);
                        if (cd_log != '0) begin
                            cd_log <= cd_log - LW'(1);
                        end else if (seq_log < LW'(L)) begin
                            // new distance is (seq_log + 1) - 1, i.e. the old seq_log
                            seq_log <= seq_log + LW'(1);
                            cd_log  <= seq_log;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from registered state; load_en alone looks at
    // in_valid, and is masked by abort and reset so a cancelled accept never loads.
    assign bus.in_ready   = (state == IDLE);
    assign bus.load_en    = (state == IDLE) && bus.in_valid && !bus.abort && rst;
    assign bus.step_valid = (state == RUN);
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.last_step  = (state == RUN) && (seq_log == LW'(L)) && (cd_log == '0);
    assign bus.seq_log    = seq_log;
    assign bus.cd_log     = cd_log;
    assign bus.step_idx   = step_idx;
    assign bus.dir_final  = dir_final;
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed bench for bitonic_sort_ctrl: DEPTH=8 and DEPTH=2 instances driven
// from one linear stimulus sequence, with hand-computed expected step tables.
module tb_bitonic_sort_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    bitonic_sort_ctrl_if #(.DEPTH(8)) if8 ();
    bitonic_sort_ctrl_if #(.DEPTH(2)) if2 ();

    bitonic_sort_ctrl #(.DEPTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.master));
    bitonic_sort_ctrl #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(if2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // (seq_log, cd_log) order for an 8-element sort
    int seq_exp [6] = '{1, 2, 2, 3, 3, 3};
    int cd_exp  [6] = '{0, 1, 0, 2, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_step8(input string tag, input int i);
        check({tag, "_valid"}, 32'(if8.step_valid), 32'd1);
        check({tag, "_seq"},   32'(if8.seq_log),    32'(seq_exp[i]));
        check({tag, "_cd"},    32'(if8.cd_log),     32'(cd_exp[i]));
        check({tag, "_idx"},   32'(if8.step_idx),   32'(i));
        check({tag, "_last"},  32'(if8.last_step),  32'(i == 5));
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b0;
        {if8.in_valid, if8.descend, if8.step_ack, if8.out_ready, if8.abort} = '0;
        {if2.in_valid, if2.descend, if2.step_ack, if2.out_ready, if2.abort} = '0;

        // Reset held with random inputs
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            {if8.in_valid, if8.descend, if8.step_ack, if8.out_ready, if8.abort} = 5'($urandom);
            {if2.in_valid, if2.descend, if2.step_ack, if2.out_ready, if2.abort} = 5'($urandom);
            #1;
            check("rst_in_ready", 32'(if8.in_ready),   32'd1);
            check("rst_load_en",  32'(if8.load_en),    32'd0);
            check("rst_step_vld", 32'(if8.step_valid), 32'd0);
            check("rst_out_vld",  32'(if8.out_valid),  32'd0);
            check("rst_last",     32'(if8.last_step),  32'd0);
            check("rst_busy",     32'(if8.busy),       32'd0);
            check("rst_fields",   {if8.seq_log, if8.cd_log, if8.step_idx, if8.dir_final}, 32'd0);
            check("rst2_busy",    32'(if2.busy),       32'd0);
            check("rst2_load_en", 32'(if2.load_en),    32'd0);
        end
        @(negedge clk);
        {if8.in_valid, if8.descend, if8.step_ack, if8.out_ready, if8.abort} = '0;
        {if2.in_valid, if2.descend, if2.step_ack, if2.out_ready, if2.abort} = '0;
        rst = 1'b1;
        tick();
        check("post_rst_busy",     32'(if8.busy),     32'd0);
        check("post_rst_in_ready", 32'(if8.in_ready), 32'd1);

        // Full job, acks tied high, descending
        if8.in_valid = 1'b1;
        if8.descend  = 1'b1;
        if8.step_ack = 1'b1;
        #1;
        check("full_load_en", 32'(if8.load_en), 32'd1);
        tick();
        if8.in_valid = 1'b0;
        if8.descend  = 1'b0;
        #1;
        check("full_load_en_off", 32'(if8.load_en), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_step8("full", i);
            tick();
        end
        check("full_out_valid", 32'(if8.out_valid),  32'd1);
        check("full_dir_final", 32'(if8.dir_final),  32'd1);
        check("full_in_ready",  32'(if8.in_ready),   32'd0);
        check("full_step_off",  32'(if8.step_valid), 32'd0);
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        if8.step_ack  = 1'b0;
        check("full_idle", 32'(if8.in_ready), 32'd1);

        // Stalled acks: every third cycle, ascending
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) begin
                if8.step_ack = (j == 2);
                check_step8("stall", i);
                tick();
            end
        end
        if8.step_ack = 1'b0;
        check("stall_out_valid", 32'(if8.out_valid), 32'd1);
        check("stall_dir_final", 32'(if8.dir_final), 32'd0);

        // Output backpressure
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(if8.out_valid), 32'd1);
            check("bp_in_ready",  32'(if8.in_ready),  32'd0);
            tick();
        end
        if8.out_ready = 1'b1;
        check("bp_release_valid", 32'(if8.out_valid), 32'd1);
        tick();
        if8.out_ready = 1'b0;
        check("bp_idle_ready", 32'(if8.in_ready),  32'd1);
        check("bp_idle_valid", 32'(if8.out_valid), 32'd0);
        check("bp_idle_busy",  32'(if8.busy),      32'd0);

        // Abort at step_idx 3
        if8.in_valid = 1'b1;
        if8.step_ack = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        repeat (3) tick();
        check("abort_at_idx", 32'(if8.step_idx), 32'd3);
        if8.abort = 1'b1;
        tick();
        if8.abort = 1'b0;
        check("abort_busy",     32'(if8.busy),       32'd0);
        check("abort_in_ready", 32'(if8.in_ready),   32'd1);
        check("abort_step_off", 32'(if8.step_valid), 32'd0);
        check("abort_no_out",   32'(if8.out_valid),  32'd0);
        tick();
        check("abort_still_no_out", 32'(if8.out_valid), 32'd0);

        // Abort together with in_valid in IDLE
        if8.in_valid = 1'b1;
        if8.abort    = 1'b1;
        #1;
        check("abort_idle_load_en", 32'(if8.load_en), 32'd0);
        tick();
        check("abort_idle_busy", 32'(if8.busy), 32'd0);
        if8.abort = 1'b0;
        #1;
        check("restart_load_en", 32'(if8.load_en), 32'd1);
        tick();
        if8.in_valid = 1'b0;
        check_step8("restart", 0);
        if8.out_ready = 1'b1;
        repeat (6) tick();
        check("restart_out_valid", 32'(if8.out_valid), 32'd1);
        tick();
        if8.out_ready = 1'b0;
        if8.step_ack  = 1'b0;
        check("restart_idle", 32'(if8.in_ready), 32'd1);

        // Asynchronous reset mid-job
        if8.in_valid = 1'b1;
        if8.step_ack = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", 32'(if8.busy),    32'd0);
        check("async_rst_seq",  32'(if8.seq_log), 32'd0);
        check("async_rst_idx",  32'(if8.step_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        if8.step_ack = 1'b0;
        tick();
        check("async_rel_idle", 32'(if8.in_ready), 32'd1);

        // DEPTH=2 instance: single step
        if2.in_valid = 1'b1;
        if2.step_ack = 1'b1;
        tick();
        if2.in_valid = 1'b0;
        check("d2_step_valid", 32'(if2.step_valid), 32'd1);
        check("d2_seq",        32'(if2.seq_log),    32'd1);
        check("d2_cd",         32'(if2.cd_log),     32'd0);
        check("d2_idx",        32'(if2.step_idx),   32'd0);
        check("d2_last",       32'(if2.last_step),  32'd1);
        tick();
        check("d2_out_valid", 32'(if2.out_valid),  32'd1);
        check("d2_step_off",  32'(if2.step_valid), 32'd0);
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        check("d2_idle_ready", 32'(if2.in_ready), 32'd1);
        check("d2_idle_busy",  32'(if2.busy),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
